// File: rtl/mem_seq_pkg.sv
// ============================================================================
// Module      : mem_seq_pkg
// Description : Shared access-size codes, sequencer state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_seq_pkg;

    localparam logic [2:0] SZ_NONE = 3'd0;
    localparam logic [2:0] SZ_B    = 3'd1;
    localparam logic [2:0] SZ_H    = 3'd2;
    localparam logic [2:0] SZ_W    = 3'd4;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_XFER = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

    function automatic logic size_ok(input logic [2:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W);
    endfunction

    // Index of the final byte for a legal size code.
    function automatic logic [1:0] last_idx(input logic [2:0] sz);
        case (sz)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_seq_ext.sv
// ============================================================================
// Module      : mem_seq_ext
// Description : Sizes and zero/sign-extends assembled little-endian load bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_seq_ext
    import mem_seq_pkg::*;
(
    input  logic [31:0] i_bytes,
    input  logic [2:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_bytes;
        case (i_size)
            SZ_B:    o_data = {{24{i_sign & i_bytes[7]}},  i_bytes[7:0]};
            SZ_H:    o_data = {{16{i_sign & i_bytes[15]}}, i_bytes[15:0]};
            SZ_W:    o_data = i_bytes;
            default: o_data = i_bytes;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_seq.sv
// ============================================================================
// Module      : mem_seq
// Description : Splits 1/2/4-byte loads and stores into byte bus transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [2:0]    i_insize,
    input  logic          i_insign,
    input  logic [2:0]    i_outsize,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [31:0]   o_rdata,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [7:0]    i_mem_rdata
);

    localparam int             WCW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] c_WLIM = WCW'(TIMEOUT - 1);

    ms_state_t       r_state,  w_state_nxt;
    logic [1:0]      r_idx,    w_idx_nxt;
    logic [WCW-1:0]  r_wcnt,   w_wcnt_nxt;
    logic [31:0]     r_buf,    w_buf_nxt;
    logic            r_load,   w_load_nxt;
    logic            r_sign,   w_sign_nxt;
    logic [2:0]      r_size,   w_size_nxt;
    logic [1:0]      r_last,   w_last_nxt;
    logic [AW-1:0]   r_addr,   w_addr_nxt;
    logic [31:0]     r_wdata,  w_wdata_nxt;
    logic            r_busy,   w_busy_nxt;
    logic            r_done,   w_done_nxt;
    logic            r_err,    w_err_nxt;
    logic [31:0]     r_rdata,  w_rdata_nxt;
    logic            r_req,    w_req_nxt;
    logic            r_we,     w_we_nxt;
    logic [AW-1:0]   r_maddr,  w_maddr_nxt;
    logic [7:0]      r_mwdata, w_mwdata_nxt;

    logic            w_ld_ok;
    logic            w_st_ok;
    logic            w_valid;
    logic [2:0]      w_sel_size;
    logic [1:0]      w_idx_inc;
    logic [31:0]     w_asm;
    logic [31:0]     w_ext;

    // Exactly one direction may carry a legal size; anything else is an error.
    assign w_ld_ok    = size_ok(i_insize)  && (i_outsize == SZ_NONE);
    assign w_st_ok    = size_ok(i_outsize) && (i_insize  == SZ_NONE);
    assign w_valid    = w_ld_ok | w_st_ok;
    assign w_sel_size = w_ld_ok ? i_insize : i_outsize;
    assign w_idx_inc  = r_idx + 2'd1;

    always_comb begin
        w_asm                        = r_buf;
        w_asm[{r_idx, 3'b000} +: 8]  = i_mem_rdata;
    end

    mem_seq_ext u_ext (
        .i_bytes (w_asm),
        .i_size  (r_size),
        .i_sign  (r_sign),
        .o_data  (w_ext)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_wcnt_nxt   = r_wcnt;
        w_buf_nxt    = r_buf;
        w_load_nxt   = r_load;
        w_sign_nxt   = r_sign;
        w_size_nxt   = r_size;
        w_last_nxt   = r_last;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_rdata_nxt  = r_rdata;
        w_req_nxt    = r_req;
        w_we_nxt     = r_we;
        w_maddr_nxt  = r_maddr;
        w_mwdata_nxt = r_mwdata;

        case (r_state)
            MS_IDLE: begin
                if (i_start) begin
                    if (w_valid) begin
                        w_state_nxt  = MS_XFER;
                        w_idx_nxt    = 2'd0;
                        w_wcnt_nxt   = '0;
                        w_buf_nxt    = '0;
                        w_load_nxt   = w_ld_ok;
                        w_sign_nxt   = i_insign;
                        w_size_nxt   = w_sel_size;
                        w_last_nxt   = last_idx(w_sel_size);
                        w_addr_nxt   = i_addr;
                        w_wdata_nxt  = i_wdata;
                        w_req_nxt    = 1'b1;
                        w_we_nxt     = ~w_ld_ok;
                        w_maddr_nxt  = i_addr;
                        w_mwdata_nxt = i_wdata[7:0];
                    end else begin
                        w_state_nxt  = MS_DONE;
                        w_done_nxt   = 1'b1;
                        w_err_nxt    = 1'b1;
                        w_rdata_nxt  = '0;
                    end
                end
            end
            MS_XFER: begin
                if (i_mem_ack) begin
                    w_wcnt_nxt = '0;
                    if (r_load) begin
                        w_buf_nxt = w_asm;
                    end
                    if (r_idx == r_last) begin
                        w_state_nxt = MS_DONE;
                        w_done_nxt  = 1'b1;
                        w_req_nxt   = 1'b0;
                        w_we_nxt    = 1'b0;
                        w_rdata_nxt = r_load ? w_ext : 32'd0;
                    end else begin
                        // Address wraps naturally at 2^AW.
                        w_idx_nxt    = w_idx_inc;
                        w_maddr_nxt  = r_addr + AW'(w_idx_inc);
                        w_mwdata_nxt = r_wdata[{w_idx_inc, 3'b000} +: 8];
                    end
                end else if ((TIMEOUT != 0) && (r_wcnt == c_WLIM)) begin
                    w_state_nxt = MS_DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_rdata_nxt = '0;
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            MS_DONE: begin
                w_state_nxt = MS_IDLE;
            end
            default: begin
                w_state_nxt = MS_IDLE;
                w_req_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != MS_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= MS_IDLE;
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_buf    <= '0;
            r_load   <= 1'b0;
            r_sign   <= 1'b0;
            r_size   <= SZ_NONE;
            r_last   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_maddr  <= '0;
            r_mwdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_buf    <= w_buf_nxt;
            r_load   <= w_load_nxt;
            r_sign   <= w_sign_nxt;
            r_size   <= w_size_nxt;
            r_last   <= w_last_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_rdata  <= w_rdata_nxt;
            r_req    <= w_req_nxt;
            r_we     <= w_we_nxt;
            r_maddr  <= w_maddr_nxt;
            r_mwdata <= w_mwdata_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_mem_req   = r_req;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_maddr;
    assign o_mem_wdata = r_mwdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_seq.sv
// ============================================================================
// Module      : tb_mem_seq
// Description : Directed self-checking bench for the mem_seq byte sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  insize;
    logic        insign;
    logic [2:0]  outsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    // Memory model: preloaded read bytes plus a log of written bytes.
    logic [7:0]  rom [logic [31:0]];
    logic [31:0] wr_addr [0:15];
    logic [7:0]  wr_data [0:15];
    int          wr_n = 0;
    int          wcnt = 0;
    int          ack_waits = 0;
    logic        blk_en = 1'b0;
    logic [31:0] blk_addr = 32'h0;
    logic [31:0] got;

    mem_seq #(.AW(32), .TIMEOUT(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_insize    (insize),
        .i_insign    (insign),
        .i_outsize   (outsize),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_rdata     (rdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_rd(input logic [31:0] a);
        return rom.exists(a) ? rom[a] : 8'h00;
    endfunction

    assign mem_ack   = mem_req && (wcnt == ack_waits) && !(blk_en && (mem_addr == blk_addr));
    assign mem_rdata = rom_rd(mem_addr);

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            wcnt <= 0;
            if (mem_we) begin
                wr_addr[wr_n[3:0]] <= mem_addr;
                wr_data[wr_n[3:0]] <= mem_wdata;
                wr_n               <= wr_n + 1;
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] isz, input logic sg, input logic [2:0] osz,
                      input logic [31:0] a, input logic [31:0] wd);
        start   = 1'b1;
        insize  = isz;
        insign  = sg;
        outsize = osz;
        addr    = a;
        wdata   = wd;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic do_load(input string tag, input logic [2:0] isz, input logic sg,
                           input logic [31:0] a, output logic [31:0] res);
        go(isz, sg, 3'd0, a, 32'h0);
        wait_done(tag, 20);
        chk(tag, {63'd0, err}, 64'd0);
        res = rdata;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        insize  = 3'd0;
        insign  = 1'b0;
        outsize = 3'd0;
        addr    = 32'h0;
        wdata   = 32'h0;
        rom[32'h100] = 8'h78; rom[32'h101] = 8'h56;
        rom[32'h102] = 8'h34; rom[32'h103] = 8'h12;
        rom[32'h200] = 8'h80;
        rom[32'h300] = 8'h01; rom[32'h301] = 8'hFF;

        // Reset state
        #12;
        chk("rst_busy",  {63'd0, busy},    64'd0);
        chk("rst_done",  {63'd0, done},    64'd0);
        chk("rst_err",   {63'd0, err},     64'd0);
        chk("rst_req",   {63'd0, mem_req}, 64'd0);
        chk("rst_we",    {63'd0, mem_we},  64'd0);
        chk("rst_rdata", {32'd0, rdata},   64'd0);
        chk("rst_maddr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mwd",   {56'd0, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        tick();

        // LW with zero-wait memory: one byte per cycle, done right after the last
        go(3'd4, 1'b0, 3'd0, 32'h100, 32'h0);
        chk("lw_busy", {63'd0, busy},   64'd1);
        chk("lw_we",   {63'd0, mem_we}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("lw_req",  {63'd0, mem_req}, 64'd1);
            chk("lw_addr", {32'd0, mem_addr}, 64'h100 + 64'(i));
            tick();
        end
        chk("lw_done",  {63'd0, done},    64'd1);
        chk("lw_err",   {63'd0, err},     64'd0);
        chk("lw_req_off", {63'd0, mem_req}, 64'd0);
        chk("lw_rdata", {32'd0, rdata},   64'h12345678);
        tick();
        chk("lw_idle_busy", {63'd0, busy}, 64'd0);
        chk("lw_idle_done", {63'd0, done}, 64'd0);

        // Sized loads with and without sign extension
        do_load("lb_s", 3'd1, 1'b1, 32'h200, got);
        chk("lb_s_val", {32'd0, got}, 64'hFFFFFF80);
        do_load("lbu", 3'd1, 1'b0, 32'h200, got);
        chk("lbu_val", {32'd0, got}, 64'h00000080);
        do_load("lh_s", 3'd2, 1'b1, 32'h300, got);
        chk("lh_s_val", {32'd0, got}, 64'hFFFFFF01);

        // Illegal size combinations: immediate error, no bus traffic, rdata cleared
        go(3'd3, 1'b0, 3'd0, 32'h100, 32'h0);
        chk("bad3_done",  {63'd0, done},    64'd1);
        chk("bad3_err",   {63'd0, err},     64'd1);
        chk("bad3_req",   {63'd0, mem_req}, 64'd0);
        chk("bad3_rdata", {32'd0, rdata},   64'd0);
        chk("bad3_busy",  {63'd0, busy},    64'd1);
        tick();
        chk("bad3_idle",  {63'd0, busy},    64'd0);
        do_load("lh_again", 3'd2, 1'b1, 32'h300, got);
        go(3'd1, 1'b0, 3'd4, 32'h100, 32'h0);
        chk("both_done",  {63'd0, done},    64'd1);
        chk("both_err",   {63'd0, err},     64'd1);
        chk("both_req",   {63'd0, mem_req}, 64'd0);
        chk("both_rdata", {32'd0, rdata},   64'd0);
        tick();
        go(3'd0, 1'b0, 3'd0, 32'h100, 32'h0);
        chk("none_done", {63'd0, done}, 64'd1);
        chk("none_err",  {63'd0, err},  64'd1);
        tick();

        // STH across the top of the address space with 2 wait cycles per byte
        ack_waits = 2;
        go(3'd0, 1'b0, 3'd2, 32'hFFFFFFFF, 32'hAABBCCDD);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) begin
                chk("sth_req",  {63'd0, mem_req}, 64'd1);
                chk("sth_we",   {63'd0, mem_we},  64'd1);
                chk("sth_addr", {32'd0, mem_addr}, (b == 0) ? 64'hFFFFFFFF : 64'h0);
                chk("sth_wd",   {56'd0, mem_wdata}, (b == 0) ? 64'hDD : 64'hCC);
                tick();
            end
        end
        chk("sth_done", {63'd0, done}, 64'd1);
        chk("sth_err",  {63'd0, err},  64'd0);
        chk("sth_nwr",  64'(wr_n), 64'd2);
        chk("sth_a0",   {32'd0, wr_addr[0]}, 64'hFFFFFFFF);
        chk("sth_d0",   {56'd0, wr_data[0]}, 64'hDD);
        chk("sth_a1",   {32'd0, wr_addr[1]}, 64'h0);
        chk("sth_d1",   {56'd0, wr_data[1]}, 64'hCC);
        tick();
        ack_waits = 0;

        // Timeout on byte 1 of an LW; a start pulse while busy must be ignored
        do_load("lb_pre", 3'd1, 1'b1, 32'h200, got);
        blk_en   = 1'b1;
        blk_addr = 32'h101;
        go(3'd4, 1'b0, 3'd0, 32'h100, 32'h0);
        start  = 1'b1;
        insize = 3'd1;
        addr   = 32'h500;
        tick();
        chk("to_addr", {32'd0, mem_addr}, 64'h101);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_wait_req",  {63'd0, mem_req}, 64'd1);
            chk("to_wait_addr", {32'd0, mem_addr}, 64'h101);
        end
        tick();
        chk("to_done",  {63'd0, done},    64'd1);
        chk("to_err",   {63'd0, err},     64'd1);
        chk("to_req",   {63'd0, mem_req}, 64'd0);
        chk("to_rdata", {32'd0, rdata},   64'd0);
        tick();
        chk("to_start_on_done", {63'd0, busy}, 64'd0);
        start = 1'b0;
        tick();
        chk("to_idle", {63'd0, busy | mem_req}, 64'd0);
        blk_en = 1'b0;

        // Asynchronous reset in the middle of a word store
        go(3'd0, 1'b0, 3'd4, 32'h400, 32'h11223344);
        tick();
        tick();
        chk("rst_mid_addr", {32'd0, mem_addr}, 64'h402);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_req",  {63'd0, mem_req}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy},    64'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_mid_nwr", 64'(wr_n), 64'd4);
        chk("rst_mid_a2",  {32'd0, wr_addr[2]}, 64'h400);
        chk("rst_mid_d2",  {56'd0, wr_data[2]}, 64'h44);
        chk("rst_mid_d3",  {56'd0, wr_data[3]}, 64'h33);
        do_load("lb_after", 3'd1, 1'b1, 32'h100, got);
        chk("lb_after_val", {32'd0, got}, 64'h00000078);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
